vga_pixel_unpack: RTL and testbench
===================================

VGA_PIXEL_UNPACK -- requirements
Module: vga_pixel_unpack

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, FIFO word width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-003 SHALL have port sclr  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port color_depth  input  2  00=8bpp, 01=16bpp, 10=32bpp, 11=treated as 32bpp.
REQ-005 SHALL have port fifo_q  input  DWIDTH  FIFO read data, valid the cycle after fifo_rreq.
REQ-006 SHALL have port fifo_empty  input  1  FIFO holds no words.
REQ-007 SHALL have port fifo_rreq  output  1  FIFO read request, one word per asserted cycle.
REQ-008 SHALL have port pix_req  input  1  downstream consumes one pixel this cycle.
REQ-009 SHALL have port pix_vld  output  1  pix_data holds a valid pixel.
REQ-010 SHALL have port pix_data  output  32  current pixel, right-aligned and zero-extended.
REQ-011 SHALL have port underrun  output  1  sticky flag: pix_req was seen while pix_vld=0.

Function
REQ-012 SHALL keep a 2-entry word buffer plus an in-flight counter (0..2) for issued, unreturned reads.
REQ-013 SHALL capture fifo_q into the buffer tail exactly one cycle after each fifo_rreq.
REQ-014 SHALL drive fifo_rreq = !sclr & !fifo_empty & (buffered + in_flight - pop_this_cycle < 2); combinational path from pix_req is permitted.
REQ-015 SHALL assert pix_vld whenever the buffer holds at least one word; pix_data is combinational from the head word and the pixel index idx.
REQ-016 SHALL select pix_data as follows: 8bpp byte idx (0..3); 16bpp halfword idx (0..1); 32bpp whole word (idx=0).
REQ-017 SHALL advance idx on pix_req & pix_vld; at the last idx for the depth (3/1/0) it pops the head word and returns idx to 0 in the same cycle.
REQ-018 SHALL sustain one pixel per clock in 32bpp mode while the FIFO stays non-empty, after a 2-cycle startup.
REQ-019 SHALL ignore pix_req while pix_vld=0, with no idx change and no pop, and set underrun on that cycle.
REQ-020 SHALL latch color_depth into an internal register only while sclr=1; changes at other times have no effect.
REQ-021 SHALL never exceed 2 buffered+in-flight words, so no returned word is dropped; when a pop and a capture occur in the same cycle, the captured word becomes the new tail.

Reset
REQ-022 SHALL clear the following on sclr: buffer to empty, in_flight to 0, idx to 0, underrun to 0, pix_vld to 0, and pix_data to 0.
REQ-023 SHALL discard a fifo_q return that is due in the cycle after sclr; sclr mid-stream leaves no stale pixel.

Configuration
REQ-024 SHALL, when VGA_UNPACK_MSB_FIRST_EN is defined, map idx 0 to the most-significant sub-word (byte 3 / halfword 1).
REQ-025 SHALL, when VGA_UNPACK_MSB_FIRST_EN is not defined, map idx 0 to the least-significant sub-word (byte 0 / halfword 0); 32bpp behaviour is identical in both cases.

Structure
REQ-026 SHALL take the color_depth encodings (CD_8BPP, CD_16BPP, CD_32BPP) and the last-index-per-depth constants from shared package vga_pkg.
REQ-027 SHALL implement the 2-entry buffer with in-flight accounting as sub-module vga_word_buf; sub-word selection and idx control remain in vga_pixel_unpack.

Verification
REQ-028 SHALL cover: sclr with color_depth=00, one FIFO word 0xAABBCCDD, pix_req held high -> pix_data 0xDD,0xCC,0xBB,0xAA on consecutive valid cycles, then pix_vld=0 (macro undefined).
REQ-029 SHALL cover: the same stimulus with VGA_UNPACK_MSB_FIRST_EN defined -> 0xAA,0xBB,0xCC,0xDD.
REQ-030 SHALL cover: 16bpp, words 0x11112222 and 0x33334444 -> 0x2222,0x1111,0x4444,0x3333, with fifo_rreq pulsed exactly twice.
REQ-031 SHALL cover: 32bpp, 8 words preloaded, pix_req constant 1 -> 8 pixels on 8 consecutive cycles after startup, with in_flight+buffered never above 2.
REQ-032 SHALL cover: empty FIFO with pix_req=1 -> pix_vld=0, underrun=1 and sticky until sclr, and fifo_rreq=0.
REQ-033 SHALL cover: sclr asserted the cycle after a fifo_rreq -> the returned word is discarded, pix_vld=0, and idx restarts at 0 on the next word.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared color-depth encodings and per-depth last pixel index for the VGA pixel path.
package vga_pkg;

    typedef enum logic [1:0] {
        CD_8BPP      = 2'b00,
        CD_16BPP     = 2'b01,
        CD_32BPP     = 2'b10,
        CD_32BPP_ALT = 2'b11
    } color_depth_t;

    localparam logic [1:0] LAST_IDX_8BPP  = 2'd3;
    localparam logic [1:0] LAST_IDX_16BPP = 2'd1;
    localparam logic [1:0] LAST_IDX_32BPP = 2'd0;

    function automatic logic [1:0] last_idx(input color_depth_t cd);
        case (cd)
            CD_8BPP:  return LAST_IDX_8BPP;
            CD_16BPP: return LAST_IDX_16BPP;
            default:  return LAST_IDX_32BPP;
        endcase
    endfunction

endpackage

// File: rtl/vga_word_buf.sv
// Two-entry FIFO word buffer with in-flight read accounting; the FIFO returns data
// exactly one cycle after each read request.
module vga_word_buf #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              sclr,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_q,
    input  logic              i_pop,
    output logic              fifo_rreq,
    output logic              o_vld,
    output logic [DWIDTH-1:0] o_head
);

    logic [DWIDTH-1:0] r_buf [2];
    logic [1:0]        r_count;
    logic [1:0]        r_in_flight;
    logic              w_capture;
    logic              w_pop;
    logic [2:0]        w_occ;

    // Every in-flight read returns on the very next cycle, so a non-zero count means capture now.
    assign w_capture = (r_in_flight != 2'd0);
    assign w_pop     = i_pop & (r_count != 2'd0);
    assign w_occ     = {1'b0, r_count} + {1'b0, r_in_flight};
    assign fifo_rreq = !sclr & !fifo_empty & (w_occ < (3'd2 + {2'b00, w_pop}));
    assign o_vld     = (r_count != 2'd0);
    assign o_head    = r_buf[0];

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_count     <= 2'd0;
            r_in_flight <= 2'd0;
            r_buf[0]    <= '0;
            r_buf[1]    <= '0;
        end else begin
            r_in_flight <= r_in_flight + {1'b0, fifo_rreq} - {1'b0, w_capture};
            r_count     <= r_count + {1'b0, w_capture} - {1'b0, w_pop};
            // Occupancy never exceeds two, so a capture without a pop always has a free slot.
            case ({w_pop, w_capture})
                2'b01: r_buf[r_count[0]] <= fifo_q;
                2'b10: r_buf[0] <= r_buf[1];
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_buf[0] <= r_buf[1];
                        r_buf[1] <= fifo_q;
                    end else begin
                        r_buf[0] <= fifo_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/vga_pixel_unpack.sv
// Unpacks 32-bit FIFO words into 8/16/32 bpp pixels. Define VGA_UNPACK_MSB_FIRST_EN to
// emit the most-significant sub-word first; otherwise the least-significant comes first.
module vga_pixel_unpack
    import vga_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              sclr,
    input  logic [1:0]        color_depth,
    input  logic [DWIDTH-1:0] fifo_q,
    input  logic              fifo_empty,
    output logic              fifo_rreq,
    input  logic              pix_req,
    output logic              pix_vld,
    output logic [31:0]       pix_data,
    output logic              underrun
);

    color_depth_t      r_depth;
    logic [1:0]        r_idx;
    logic              r_underrun;
    logic              w_vld;
    logic [DWIDTH-1:0] w_head;
    logic              w_take;
    logic              w_pop;
    logic [1:0]        w_byte_sel;
    logic              w_half_sel;

    vga_word_buf #(.DWIDTH(DWIDTH)) u_buf (
        .clk        (clk),
        .sclr       (sclr),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .i_pop      (w_pop),
        .fifo_rreq  (fifo_rreq),
        .o_vld      (w_vld),
        .o_head     (w_head)
    );

    assign w_take = pix_req & w_vld;
    assign w_pop  = w_take & (r_idx == last_idx(r_depth));

`ifdef VGA_UNPACK_MSB_FIRST_EN
    assign w_byte_sel = ~r_idx;
    assign w_half_sel = ~r_idx[0];
`else
    assign w_byte_sel = r_idx;
    assign w_half_sel = r_idx[0];
`endif

    // Output is forced to zero whenever the buffer is empty so nothing stale leaks out.
    always_comb begin
        pix_data = 32'd0;
        if (w_vld) begin
            case (r_depth)
                CD_8BPP:  pix_data = {24'd0, w_head[{w_byte_sel, 3'b000} +: 8]};
                CD_16BPP: pix_data = {16'd0, w_head[{w_half_sel, 4'b0000} +: 16]};
                default:  pix_data = w_head[31:0];
            endcase
        end
    end

    assign pix_vld  = w_vld;
    assign underrun = r_underrun;

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_depth    <= (color_depth == CD_32BPP_ALT) ? CD_32BPP : color_depth_t'(color_depth);
            r_idx      <= 2'd0;
            r_underrun <= 1'b0;
        end else begin
            if (w_take) begin
                r_idx <= w_pop ? 2'd0 : r_idx + 2'd1;
            end
            if (pix_req && !w_vld) begin
                r_underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_pixel_unpack.sv
// Directed bench for vga_pixel_unpack: a behavioural FIFO with one-cycle read latency
// feeds the DUT while a linear sequence of steps checks pixels, handshakes and flags.
module tb_vga_pixel_unpack;

    logic        clk = 1'b0;
    logic        sclr;
    logic [1:0]  color_depth;
    logic [31:0] fifo_q = 32'd0;
    logic        fifo_empty;
    logic        fifo_rreq;
    logic        pix_req;
    logic        pix_vld;
    logic [31:0] pix_data;
    logic        underrun;

    logic [31:0] fifo_mem[$];
    int          pushed    = 0;
    int          popped    = 0;
    int          rreq_cnt  = 0;
    int          bad_rreq  = 0;
    int          n_pass    = 0;
    int          n_total   = 0;

    always #5 clk = ~clk;

    vga_pixel_unpack #(.DWIDTH(32)) dut (
        .clk         (clk),
        .sclr        (sclr),
        .color_depth (color_depth),
        .fifo_q      (fifo_q),
        .fifo_empty  (fifo_empty),
        .fifo_rreq   (fifo_rreq),
        .pix_req     (pix_req),
        .pix_vld     (pix_vld),
        .pix_data    (pix_data),
        .underrun    (underrun)
    );

    assign fifo_empty = (pushed == popped);

    // FIFO model: data appears on fifo_q the cycle after a read request.
    always @(posedge clk) begin
        if (fifo_rreq) begin
            rreq_cnt <= rreq_cnt + 1;
            if (fifo_mem.size() > 0) begin
                fifo_q <= fifo_mem.pop_front();
                popped <= popped + 1;
            end else begin
                bad_rreq <= bad_rreq + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        fifo_mem.push_back(w);
        pushed = pushed + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_vld(output int cycles);
        cycles = 0;
        while (!pix_vld && cycles < 10) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        logic [31:0] exp8 [4];
        logic [31:0] exp16 [4];
        logic [31:0] w32 [8];
        logic [31:0] exp_a0, exp_a1, exp_c0, exp_c1;
        int          cyc;
        int          base;
        int          occ;
        int          max_occ;

`ifdef VGA_UNPACK_MSB_FIRST_EN
        exp8  = '{32'hAA, 32'hBB, 32'hCC, 32'hDD};
        exp16 = '{32'h1111, 32'h2222, 32'h3333, 32'h4444};
        exp_a0 = 32'h01; exp_a1 = 32'h02; exp_c0 = 32'h0A; exp_c1 = 32'h0B;
`else
        exp8  = '{32'hDD, 32'hCC, 32'hBB, 32'hAA};
        exp16 = '{32'h2222, 32'h1111, 32'h4444, 32'h3333};
        exp_a0 = 32'h04; exp_a1 = 32'h03; exp_c0 = 32'h0D; exp_c1 = 32'h0C;
`endif
        for (int i = 0; i < 8; i++) w32[i] = 32'h1000_0000 + 32'h0101_0101 * i;

        // Reset state
        sclr = 1'b1; color_depth = 2'b00; pix_req = 1'b0;
        tick(); tick();
        check("rst_vld", pix_vld, 1'b0);
        check("rst_data", pix_data, 32'd0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_rreq", fifo_rreq, 1'b0);

        // 8bpp: one word, pix_req held high
        sclr = 1'b0;
        base = rreq_cnt;
        push(32'hAABBCCDD);
        pix_req = 1'b1;
        #1;
        check("t1_rreq", fifo_rreq, 1'b1);
        wait_vld(cyc);
        check("t1_startup", cyc, 2);
        for (int k = 0; k < 4; k++) begin
            check("t1_vld", pix_vld, 1'b1);
            check("t1_pix", pix_data, exp8[k]);
            tick();
        end
        check("t1_vld_end", pix_vld, 1'b0);
        check("t1_data_end", pix_data, 32'd0);
        check("t1_rreq_cnt", rreq_cnt - base, 1);

        // 16bpp: two words, exactly two reads
        pix_req = 1'b0; sclr = 1'b1; color_depth = 2'b01;
        tick();
        sclr = 1'b0;
        base = rreq_cnt;
        push(32'h11112222);
        push(32'h33334444);
        pix_req = 1'b1;
        #1;
        wait_vld(cyc);
        check("t2_startup", cyc, 2);
        for (int k = 0; k < 4; k++) begin
            check("t2_vld", pix_vld, 1'b1);
            check("t2_pix", pix_data, exp16[k]);
            tick();
        end
        check("t2_vld_end", pix_vld, 1'b0);
        check("t2_rreq_cnt", rreq_cnt - base, 2);

        // 32bpp: eight preloaded words streamed at one pixel per clock
        pix_req = 1'b0; sclr = 1'b1; color_depth = 2'b10;
        for (int i = 0; i < 8; i++) push(w32[i]);
        tick();
        check("t3_rreq_in_rst", fifo_rreq, 1'b0);
        sclr = 1'b0;
        base = rreq_cnt;
        max_occ = 0;
        pix_req = 1'b1;
        #1;
        wait_vld(cyc);
        check("t3_startup", cyc, 2);
        for (int k = 0; k < 8; k++) begin
            check("t3_vld", pix_vld, 1'b1);
            check("t3_pix", pix_data, w32[k]);
            tick();
            occ = (rreq_cnt - base) - (k + 1);
            if (occ > max_occ) max_occ = occ;
        end
        check("t3_vld_end", pix_vld, 1'b0);
        check("t3_rreq_cnt", rreq_cnt - base, 8);
        check("t3_occ_le2", (max_occ <= 2), 1'b1);

        // Underrun on empty FIFO
        pix_req = 1'b0; sclr = 1'b1; color_depth = 2'b00;
        tick();
        sclr = 1'b0;
        pix_req = 1'b1;
        #1;
        check("t4_rreq", fifo_rreq, 1'b0);
        check("t4_vld", pix_vld, 1'b0);
        check("t4_underrun_pre", underrun, 1'b0);
        tick();
        check("t4_underrun", underrun, 1'b1);
        check("t4_rreq2", fifo_rreq, 1'b0);
        pix_req = 1'b0;
        tick(); tick();
        check("t4_sticky", underrun, 1'b1);
        check("t4_vld2", pix_vld, 1'b0);
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        #1;
        check("t4_cleared", underrun, 1'b0);

        // sclr the cycle after a read: returned word is dropped, idx restarts
        push(32'h01020304);
        #1;
        wait_vld(cyc);
        check("t5_startup", cyc, 2);
        pix_req = 1'b1;
        #1;
        check("t5_a0", pix_data, exp_a0);
        tick();
        pix_req = 1'b0;
        #1;
        check("t5_a1", pix_data, exp_a1);
        push(32'h05060708);
        #1;
        check("t5_rreq", fifo_rreq, 1'b1);
        tick();
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        #1;
        check("t5_vld_rst", pix_vld, 1'b0);
        check("t5_data_rst", pix_data, 32'd0);
        tick(); tick();
        check("t5_vld_drop", pix_vld, 1'b0);
        push(32'h0A0B0C0D);
        pix_req = 1'b1;
        #1;
        wait_vld(cyc);
        check("t5_c_startup", cyc, 2);
        check("t5_c0", pix_data, exp_c0);
        tick();
        check("t5_c1", pix_data, exp_c1);
        pix_req = 1'b0;

        // Depth 11 behaves as 32bpp; depth changes outside sclr are ignored
        sclr = 1'b1; color_depth = 2'b11;
        tick();
        sclr = 1'b0; color_depth = 2'b00;
        push(32'hCAFEF00D);
        pix_req = 1'b1;
        #1;
        wait_vld(cyc);
        check("t6_startup", cyc, 2);
        check("t6_pix", pix_data, 32'hCAFEF00D);
        tick();
        check("t6_vld_end", pix_vld, 1'b0);
        pix_req = 1'b0;

        tick();
        check("no_read_when_empty", bad_rreq, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
